mont_pre_mod: RTL

- Upstream pre-processing stage for the 256-bit radix-4 Montgomery multiplier in the RSA datapath.
- Converts an operand Y into Montgomery form, Y_mont = Y·2^256 mod N.
- Method is bit-serial shift-and-subtract, one doubling step per clock.
- Y_mont is held stable after completion so the RSA controller can hand it to the multiplier as A or B.

---
 rtl/mont_pre_mod.sv | 130 +++++++++++++
 1 files changed

// File: rtl/mont_pre_mod.sv
// ---------------------------------------------------------------------------
// mont_pre_mod
//
// Converts an operand Y into Montgomery form, Y_mont = Y * 2^WIDTH mod N.
// This is the stage in front of the radix-4 Montgomery multiplier in the RSA
// datapath. It works bit-serially: one conditional "double then subtract N"
// step per clock.
//
// Sequence of one run:
//   IDLE : waits for start. On the accepting edge it latches Y and N.
//   LOAD : one cycle. Folds Y from [0, 2N) down into [0, N).
//   CALC : exactly WIDTH cycles of T <- 2T mod N.
//   DONE : one cycle with done high.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous reset, active HIGH (asserted = 1), despite the name
//   start  : request pulse; accepted only while ready = 1
//   Y      : operand, WIDTH bits; must satisfy Y < 2N
//   N      : modulus, WIDTH bits; expected to be odd with the MSB set
//   ready  : high only in IDLE
//   done   : one-cycle pulse that marks Y_mont as valid
//   Y_mont : result; holds its value until the final CALC edge of the next run
// ---------------------------------------------------------------------------
module mont_pre_mod #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] N,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Y_mont
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_reg;
  logic [WIDTH:0]     t_reg;       // one spare bit so that 2T never overflows
  logic [WIDTH:0]     n_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   y_mont_reg;
  logic               ready_reg;
  logic               done_reg;

  logic [WIDTH:0]     dbl_t;
  logic [WIDTH:0]     load_next;
  logic [WIDTH:0]     calc_next;

  // Both reduction steps are one conditional subtraction each. The
  // comparisons are WIDTH+1 bits wide and unsigned. Because T < N holds
  // during CALC, 2T < 2N, so a single subtraction is enough to bring the
  // value back into range.
  always_comb begin
    dbl_t     = {t_reg[WIDTH-1:0], 1'b0};
    load_next = (t_reg >= n_reg) ? (t_reg - n_reg) : t_reg;
    calc_next = (dbl_t >= n_reg) ? (dbl_t - n_reg) : dbl_t;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_reg  <= IDLE;
      t_reg      <= '0;
      n_reg      <= '0;
      cnt_reg    <= '0;
      y_mont_reg <= '0;
      ready_reg  <= 1'b1;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (start) begin
            // Latch the inputs so that Y and N may change once accepted.
            t_reg     <= {1'b0, Y};
            n_reg     <= {1'b0, N};
            ready_reg <= 1'b0;
            state_reg <= LOAD;
          end
        end

        LOAD: begin
          t_reg     <= load_next;
          cnt_reg   <= '0;
          state_reg <= CALC;
        end

        CALC: begin
          t_reg   <= calc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CNT_LAST) begin
            // Y_mont changes only here, so the previous result stays
            // visible throughout LOAD and CALC of the next run.
            y_mont_reg <= calc_next[WIDTH-1:0];
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end

        DONE: begin
          // Any start seen in this cycle is deliberately dropped.
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end

        default: begin
          done_reg  <= 1'b0;
          ready_reg <= 1'b1;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign ready  = ready_reg;
  assign done   = done_reg;
  assign Y_mont = y_mont_reg;

endmodule
